imm_ext_ctrl: RTL and testbench
===============================

// Module: imm_ext_ctrl
// PURPOSE
//  ID-stage immediate controller. Decodes the opcode of each incoming instruction,
//  selects the extension mode (sign/zero/upper/branch) and forms the 32-bit operand.
//  Result is buffered into the ID/EX boundary through a 2-entry skid buffer with a
//  valid/ready handshake and flush. Also keeps a saturating back-pressure counter.
// PARAMETERS
//  STALL_CNT_W  16  width of the saturating stall-cycle counter
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            reset: synchronous, active-high
//  flush        in   1            squash all buffered entries (branch/exception)
//  in_valid     in   1            instr valid from IF/ID
//  in_ready     out  1            buffer can accept instr this cycle
//  instr        in   32           instruction word
//  out_valid    out  1            imm32/ext_mode/imm_used valid toward EX
//  out_ready    in   1            EX accepts the head entry
//  imm32        out  32           extended immediate
//  ext_mode     out  3            0 none, 1 sign, 2 zero, 3 upper, 4 branch, 5 shamt
//  imm_used     out  1            instruction consumes an immediate
//  stall_cnt    out  STALL_CNT_W  cycles with out_valid && !out_ready (saturating)
// BEHAVIOUR
//  Decode on instr[31:26], combinational, before the buffer:
//   - 001000/001001/001010/001011/100011/101011 -> sign: {{16{i[15]}},i[15:0]}.
//   - 001100/001101/001110 -> zero: {16'b0,i[15:0]}.
//   - 001111 (lui) -> upper: {i[15:0],16'b0}.
//   - 000100/000101 -> branch: {{14{i[15]}},i[15:0],2'b00}.
//   - anything else -> none: imm32=0, imm_used=0.
//  Buffer: head reg (drives outputs) + skid reg; states EMPTY, ONE, TWO.
//   - Accept when in_valid && in_ready; pop when out_valid && out_ready.
//   - EMPTY: accept -> ONE (head loaded).
//   - ONE: accept & pop -> ONE (head reloaded); accept only -> TWO (skid loaded);
//     pop only -> EMPTY.
//   - TWO: pop -> ONE (skid moves to head); no accept possible.
//   - in_ready = (state != TWO); a registered decode of state, no comb path from out_ready.
//   - Latency: accepted instr appears on outputs next cycle when buffer was EMPTY or
//     ONE-with-pop; order strictly FIFO.
//  Flush: takes priority over accept and pop in the same cycle; next state EMPTY,
//   out_valid=0, in_ready=1; an instr offered during flush is dropped.
//   stall_cnt unaffected.
//  stall_cnt: +1 each cycle out_valid && !out_ready; holds at all-ones.
//  Reset (rst=1 at clk edge): state EMPTY, out_valid=0, in_ready=1, imm32=0,
//   ext_mode=0, imm_used=0, stall_cnt=0; rst overrides flush and all traffic.
//  Output fields hold value while out_valid && !out_ready (stable under stall).
// CONFIGURATION
//  IMM_EXT_SHAMT_EN defined: opcode 000000 with funct instr[5:0] in {000000,000010,
//   000011} -> ext_mode=5, imm32={27'b0,i[10:6]}, imm_used=1.
//  Not defined: those encodings decode as none (imm32=0, ext_mode=0, imm_used=0).
// TESTING
//  T1 reset: hold rst 2 cycles -> out_valid=0, in_ready=1, stall_cnt=0, imm32=0.
//  T2 decode, out_ready=1: addi 0x2008FFFC -> imm32=0xFFFFFFFC,mode 1; ori 0x3508FFFF
//     -> 0x0000FFFF,mode 2; lui 0x3C081234 -> 0x12340000,mode 3; beq 0x1000FFFF ->
//     0xFFFFFFFC,mode 4; add 0x01095020 -> imm_used=0; each one cycle after accept.
//  T3 back-pressure: out_ready=0, push A,B -> in_ready=0 after B; C held; release
//     out_ready -> outputs A,B,C in order, no loss/dup; stall_cnt = stalled cycles.
//  T4 flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered instr
//     never appears.
//  T5 saturation (STALL_CNT_W=4): out_ready=0 for 20 cycles with out_valid=1
//     -> stall_cnt=15.
//  T6 macro: sll 0x00084080 -> with IMM_EXT_SHAMT_EN imm32=2,mode 5,imm_used=1;
//     without -> imm32=0,mode 0,imm_used=0.

Source files
------------

// File: rtl/imm_ext_ctrl.sv
// ID-stage immediate decode/extend feeding a 2-entry skid buffer toward EX.
// Optional macro IMM_EXT_SHAMT_EN adds shift-amount immediates (ext_mode 5).
module imm_ext_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            imm32,
    output logic [2:0]             ext_mode,
    output logic                   imm_used,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] M_NONE   = 3'd0;
    localparam logic [2:0] M_SIGN   = 3'd1;
    localparam logic [2:0] M_ZERO   = 3'd2;
    localparam logic [2:0] M_UPPER  = 3'd3;
    localparam logic [2:0] M_BRANCH = 3'd4;
    localparam logic [2:0] M_SHAMT  = 3'd5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    buf_state_t state;

    logic [5:0]  opcode;
    logic [15:0] imm16;
    logic        is_sign;
    logic        is_zero;
    logic        is_upper;
    logic        is_branch;
    logic        is_shamt;
    logic        unused_bits;

    logic [31:0] dec_imm;
    logic [2:0]  dec_mode;
    logic        dec_used;

    logic [31:0] skid_imm;
    logic [2:0]  skid_mode;
    logic        skid_used;

    logic accept;
    logic pop;

    assign opcode = instr[31:26];
    assign imm16  = instr[15:0];
    assign unused_bits = ^instr[25:16];

    assign is_sign = opcode inside {6'b001000, 6'b001001, 6'b001010,
                                    6'b001011, 6'b100011, 6'b101011};
    assign is_zero   = opcode inside {6'b001100, 6'b001101, 6'b001110};
    assign is_upper  = (opcode == 6'b001111);
    assign is_branch = opcode inside {6'b000100, 6'b000101};

`ifdef IMM_EXT_SHAMT_EN
    assign is_shamt = (opcode == 6'b000000) &&
                      (instr[5:0] inside {6'b000000, 6'b000010, 6'b000011});
`else
    assign is_shamt = 1'b0;
`endif

    // Opcode classes are disjoint; pick the extension for the incoming word
    always_comb begin
        dec_imm  = 32'd0;
        dec_mode = M_NONE;
        dec_used = 1'b0;
        unique case (1'b1)
            is_sign: begin
                dec_imm  = {{16{imm16[15]}}, imm16};
                dec_mode = M_SIGN;
                dec_used = 1'b1;
            end
            is_zero: begin
                dec_imm  = {16'd0, imm16};
                dec_mode = M_ZERO;
                dec_used = 1'b1;
            end
            is_upper: begin
                dec_imm  = {imm16, 16'd0};
                dec_mode = M_UPPER;
                dec_used = 1'b1;
            end
            is_branch: begin
                dec_imm  = {{14{imm16[15]}}, imm16, 2'b00};
                dec_mode = M_BRANCH;
                dec_used = 1'b1;
            end
            is_shamt: begin
                dec_imm  = {27'd0, instr[10:6]};
                dec_mode = M_SHAMT;
                dec_used = 1'b1;
            end
            default: begin
                dec_imm  = 32'd0;
                dec_mode = M_NONE;
                dec_used = 1'b0;
            end
        endcase
    end

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // Skid-buffer FSM; head regs drive outputs, handshake flags are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            imm32     <= 32'd0;
            ext_mode  <= M_NONE;
            imm_used  <= 1'b0;
            skid_imm  <= 32'd0;
            skid_mode <= M_NONE;
            skid_used <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        imm32     <= dec_imm;
                        ext_mode  <= dec_mode;
                        imm_used  <= dec_used;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        imm32    <= dec_imm;
                        ext_mode <= dec_mode;
                        imm_used <= dec_used;
                    end else if (accept) begin
                        skid_imm  <= dec_imm;
                        skid_mode <= dec_mode;
                        skid_used <= dec_used;
                        state     <= TWO;
                        in_ready  <= 1'b0;
                    end else if (pop) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        imm32    <= skid_imm;
                        ext_mode <= skid_mode;
                        imm_used <= skid_used;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of cycles where EX holds off a valid head entry
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Directed bench for imm_ext_ctrl: decode, skid buffering, flush, stall counter.
// Expectations follow IMM_EXT_SHAMT_EN when it is defined for the build.
module tb_imm_ext_ctrl;

    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   imm32;
    logic [2:0]    ext_mode;
    logic          imm_used;
    logic [SW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_ext_ctrl #(.STALL_CNT_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm32     (imm32),
        .ext_mode  (ext_mode),
        .imm_used  (imm_used),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] word;
        logic [31:0] imm;
        logic [2:0]  mode;
        logic        used;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        instr = 32'd0;

        // T1 reset
        step();
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_stall", {28'd0, stall_cnt}, 32'd0);
        check("rst_imm32", imm32, 32'd0);
        check("rst_mode", {29'd0, ext_mode}, 32'd0);
        check("rst_used", {31'd0, imm_used}, 32'd0);
        rst = 1'b0;

        // T2 decode, streamed back-to-back with out_ready=1
        vecs.push_back('{32'h2008FFFC, 32'hFFFFFFFC, 3'd1, 1'b1});
        vecs.push_back('{32'h3508FFFF, 32'h0000FFFF, 3'd2, 1'b1});
        vecs.push_back('{32'h3C081234, 32'h12340000, 3'd3, 1'b1});
        vecs.push_back('{32'h1000FFFF, 32'hFFFFFFFC, 3'd4, 1'b1});
        vecs.push_back('{32'h01095020, 32'h00000000, 3'd0, 1'b0});
        vecs.push_back('{32'h31088000, 32'h00008000, 3'd2, 1'b1});
        vecs.push_back('{32'h14000001, 32'h00000004, 3'd4, 1'b1});
        vecs.push_back('{32'h8C088000, 32'hFFFF8000, 3'd1, 1'b1});
`ifdef IMM_EXT_SHAMT_EN
        vecs.push_back('{32'h00084080, 32'h00000002, 3'd5, 1'b1});
`else
        vecs.push_back('{32'h00084080, 32'h00000000, 3'd0, 1'b0});
`endif
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            instr = vecs[i].word;
            in_valid = 1'b1;
            step();
            check($sformatf("dec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("dec%0d_imm", i), imm32, vecs[i].imm);
            check($sformatf("dec%0d_mode", i), {29'd0, ext_mode},
                  {29'd0, vecs[i].mode});
            check($sformatf("dec%0d_used", i), {31'd0, imm_used},
                  {31'd0, vecs[i].used});
        end
        in_valid = 1'b0;
        step();
        check("dec_drain", {31'd0, out_valid}, 32'd0);
        check("dec_nostall", {28'd0, stall_cnt}, 32'd0);

        // T3 back-pressure: A,B fill buffer, C held off
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h20080001;
        step();
        check("bp_a_ready", {31'd0, in_ready}, 32'd1);
        check("bp_a_imm", imm32, 32'h00000001);
        instr = 32'h34080002;
        step();
        check("bp_b_full", {31'd0, in_ready}, 32'd0);
        check("bp_b_head", imm32, 32'h00000001);
        instr = 32'h3C080003;
        step();
        step();
        check("bp_hold_imm", imm32, 32'h00000001);
        check("bp_hold_mode", {29'd0, ext_mode}, 32'd1);
        check("bp_stall3", {28'd0, stall_cnt}, 32'd3);
        out_ready = 1'b1;
        step();
        check("bp_b_out", imm32, 32'h00000002);
        check("bp_b_mode", {29'd0, ext_mode}, 32'd2);
        check("bp_reopen", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_c_out", imm32, 32'h00030000);
        check("bp_c_valid", {31'd0, out_valid}, 32'd1);
        step();
        check("bp_empty", {31'd0, out_valid}, 32'd0);
        check("bp_stall_end", {28'd0, stall_cnt}, 32'd3);

        // T4 flush while TWO with an instr offered
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h20080011;
        step();
        instr = 32'h20080022;
        step();
        check("fl_full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        instr = 32'h20080077;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_ready", {31'd0, in_ready}, 32'd1);
        check("fl_stall", {28'd0, stall_cnt}, 32'd5);
        out_ready = 1'b1;
        step();
        check("fl_nodrop", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        instr = 32'h20080033;
        step();
        in_valid = 1'b0;
        check("fl_next_valid", {31'd0, out_valid}, 32'd1);
        check("fl_next_imm", imm32, 32'h00000033);
        step();
        check("fl_next_pop", {31'd0, out_valid}, 32'd0);

        // T5 saturation of the 4-bit stall counter
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h3C08ABCD;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) step();
        check("sat_stall", {28'd0, stall_cnt}, 32'd15);
        check("sat_valid", {31'd0, out_valid}, 32'd1);
        check("sat_imm", imm32, 32'hABCD0000);
        out_ready = 1'b1;
        step();
        check("sat_pop", {31'd0, out_valid}, 32'd0);
        check("sat_hold", {28'd0, stall_cnt}, 32'd15);

        // Reset overrides flush and traffic
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h20080044;
        step();
        rst = 1'b1;
        flush = 1'b1;
        step();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        check("rst2_valid", {31'd0, out_valid}, 32'd0);
        check("rst2_stall", {28'd0, stall_cnt}, 32'd0);
        check("rst2_imm", imm32, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
